// File: rtl/pushbutton_conditioner_pkg.sv
// Shared types and defaults for the pushbutton conditioner slice.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } pb_state_e;

    localparam int unsigned DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEBOUNCE_SIM    = 8;
    localparam int unsigned CNT_W           = 20;

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// Button pins in, debounced levels / press pulses / step request out.
interface pushbutton_conditioner_if #(
    parameter int unsigned N_BUTTONS = 3
);
    logic [N_BUTTONS-1:0] Pushbutton_n;
    logic [N_BUTTONS-1:0] Pressed;
    logic [N_BUTTONS-1:0] Press_pulse;
    logic [N_BUTTONS-1:0] Step;

    modport master (output Pushbutton_n, input Pressed, input Press_pulse, input Step);
    modport slave  (input Pushbutton_n, output Pressed, output Press_pulse, output Step);
endinterface

// File: rtl/pushbutton_conditioner_debounce_fsm.sv
// One button: 2-flop synchroniser, stable-sample counter, debounce FSM and
// registered single-cycle press pulse.
module debounce_fsm
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = pb_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = pb_pkg::CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic pressed_o,
    output logic pulse_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    pb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             s;

    assign s = ~sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // With a single-cycle debounce the wait states are skipped entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = HELD;
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pressed_o = (state_q == HELD) || (state_q == RELEASE_WAIT);
    assign pulse_o   = pulse_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Conditions N active-low buttons and forwards the lowest-index press as a
// one-hot step request.
module pushbutton_conditioner
    import pb_pkg::*;
#(
    parameter int unsigned N_BUTTONS       = 3,
    parameter int unsigned DEBOUNCE_CYCLES = pb_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = pb_pkg::CNT_W
) (
    input logic                     Clock,
    input logic                     Reset,
    pushbutton_conditioner_if.slave bus
);
    logic [N_BUTTONS-1:0] pulse;
    logic [N_BUTTONS-1:0] step;
    logic                 seen;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk       (Clock),
            .rst       (Reset),
            .btn_n_i   (bus.Pushbutton_n[g]),
            .pressed_o (bus.Pressed[g]),
            .pulse_o   (pulse[g])
        );
    end

    // Higher-index pulses coinciding with a lower one are dropped, not queued.
    always_comb begin
        step = '0;
        seen = 1'b0;
        for (int unsigned i = 0; i < N_BUTTONS; i++) begin
            step[i] = pulse[i] & ~seen;
            seen    = seen | pulse[i];
        end
    end

    assign bus.Press_pulse = pulse;
    assign bus.Step        = step;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for pushbutton_conditioner with an 8-cycle debounce.
module tb_pushbutton_conditioner;
    import pb_pkg::*;

    localparam int unsigned NB = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt [NB];
    int   step_err = 0;

    pushbutton_conditioner_if #(.N_BUTTONS(NB)) bus ();

    pushbutton_conditioner #(
        .N_BUTTONS       (NB),
        .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
        .CNT_W           (CNT_W)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; sample 1 ns after each edge and tally pulses.
    task automatic tick(input int n);
        logic [NB-1:0] p, e;
        for (int k = 0; k < n; k++) begin
            @(posedge Clock);
            #1;
            p = bus.Press_pulse;
            e = p & (~p + 1'b1);
            if (bus.Step !== e) step_err++;
            for (int b = 0; b < NB; b++) if (p[b]) pulse_cnt[b]++;
        end
    endtask

    task automatic clear_counts();
        for (int b = 0; b < NB; b++) pulse_cnt[b] = 0;
    endtask

    initial begin
        bus.Pushbutton_n = '1;
        clear_counts();
        #12;
        check("reset_pressed", 32'(bus.Pressed), 0);
        check("reset_pulse", 32'(bus.Press_pulse), 0);
        check("reset_step", 32'(bus.Step), 0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        tick(4);

        // 1: clean press on bit 0
        bus.Pushbutton_n = 3'b110;
        tick(9);
        check("t1_pulse_early", 32'(bus.Press_pulse), 0);
        check("t1_pressed_early", 32'(bus.Pressed), 0);
        tick(1);
        check("t1_pulse", 32'(bus.Press_pulse), 3'b001);
        check("t1_pressed", 32'(bus.Pressed), 3'b001);
        check("t1_step", 32'(bus.Step), 3'b001);
        tick(1);
        check("t1_pulse_off", 32'(bus.Press_pulse), 0);
        clear_counts();
        tick(40);
        check("t1_hold_pressed", 32'(bus.Pressed), 3'b001);
        check("t1_no_repeat", pulse_cnt[0], 0);

        // 3: release bounce on bit 0
        bus.Pushbutton_n[0] = 1'b1; tick(4);
        bus.Pushbutton_n[0] = 1'b0; tick(2);
        bus.Pushbutton_n[0] = 1'b1;
        tick(9);
        check("t3_pressed_held", 32'(bus.Pressed), 3'b001);
        tick(1);
        check("t3_pressed_fall", 32'(bus.Pressed), 0);
        check("t3_no_pulse", pulse_cnt[0], 0);
        tick(20);

        // 2: press bounce on bit 1
        clear_counts();
        bus.Pushbutton_n[1] = 1'b0; tick(3);
        bus.Pushbutton_n[1] = 1'b1; tick(2);
        bus.Pushbutton_n[1] = 1'b0; tick(5);
        bus.Pushbutton_n[1] = 1'b1; tick(1);
        bus.Pushbutton_n[1] = 1'b0;
        tick(9);
        check("t2_no_early", pulse_cnt[1], 0);
        check("t2_pressed_early", 32'(bus.Pressed), 0);
        tick(1);
        check("t2_pulse", 32'(bus.Press_pulse), 3'b010);
        check("t2_step", 32'(bus.Step), 3'b010);
        bus.Pushbutton_n[1] = 1'b1;
        tick(20);
        check("t2_one_pulse", pulse_cnt[1], 1);

        // 4: simultaneous press on bits 0 and 2
        bus.Pushbutton_n = 3'b010;
        tick(9);
        check("t4_pulse_early", 32'(bus.Press_pulse), 0);
        tick(1);
        check("t4_pulse", 32'(bus.Press_pulse), 3'b101);
        check("t4_step", 32'(bus.Step), 3'b001);
        check("t4_pressed", 32'(bus.Pressed), 3'b101);
        tick(1);
        check("t4_step_off", 32'(bus.Step), 0);
        bus.Pushbutton_n = '1;
        tick(20);

        // 5: reset with bit 2 held and bit 0 mid-debounce (counter = 5)
        bus.Pushbutton_n = 3'b011;
        tick(12);
        check("t5_held2", 32'(bus.Pressed), 3'b100);
        bus.Pushbutton_n = 3'b010;
        tick(7);
        Reset = 1'b1;
        #1;
        check("t5_async_pressed", 32'(bus.Pressed), 0);
        check("t5_async_pulse", 32'(bus.Press_pulse), 0);
        check("t5_async_step", 32'(bus.Step), 0);
        tick(3);
        Reset = 1'b0;
        clear_counts();
        tick(9);
        check("t5_no_early", pulse_cnt[0] + pulse_cnt[2], 0);
        tick(1);
        check("t5_pulse", 32'(bus.Press_pulse), 3'b101);
        check("t5_step", 32'(bus.Step), 3'b001);
        bus.Pushbutton_n = '1;
        tick(20);

        // 6: long hold, glitch, then a clean second press on bit 1
        clear_counts();
        bus.Pushbutton_n[1] = 1'b0; tick(1000);
        check("t6_long_pressed", 32'(bus.Pressed), 3'b010);
        bus.Pushbutton_n[1] = 1'b1; tick(20);
        bus.Pushbutton_n[1] = 1'b0; tick(5);
        bus.Pushbutton_n[1] = 1'b1; tick(20);
        check("t6_glitch_pressed", 32'(bus.Pressed), 0);
        bus.Pushbutton_n[1] = 1'b0; tick(20);
        bus.Pushbutton_n[1] = 1'b1; tick(20);
        check("t6_two_pulses", pulse_cnt[1], 2);

        check("step_onehot_all_cycles", step_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
